twiddle_mult8: RTL and testbench

TWIDDLE_MULT8 -- requirements
Module: twiddle_mult8

---
 rtl/twiddle_mult8.sv | 137 +++++++++++++
 tb/tb_twiddle_mult8.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_mult8.sv
// ============================================================================
//  Module   : twiddle_mult8
//  Purpose  : 8-point complex twiddle multiplier, 2-cycle pipeline with
//             rounding and saturation back to the sample width.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module twiddle_mult8 #(
    parameter int DW = 16,
    parameter int TW = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic [2:0]           out_k,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i
);

    localparam int c_pw = DW + TW;      // single partial product
    localparam int c_sw = DW + TW + 1;  // sum of two partial products
    localparam int c_rw = DW + TW + 2;  // headroom for the rounding offset

    localparam logic signed [c_rw-1:0] c_round = c_rw'(64);
    localparam logic signed [c_rw-1:0] c_max   = c_rw'((2 ** (DW - 1)) - 1);
    localparam logic signed [c_rw-1:0] c_min   = ~c_max;

    logic [2:0]            r_k;
    logic [2:0]            w_k_use;
    logic signed [TW-1:0]  w_wr;
    logic signed [TW-1:0]  w_wi;
    logic signed [c_pw-1:0] w_a;
    logic signed [c_pw-1:0] w_b;

    logic                   r_s1_valid;
    logic                   r_s1_sof;
    logic [2:0]             r_s1_k;
    logic signed [c_pw-1:0] r_p_ar;
    logic signed [c_pw-1:0] r_p_bi;
    logic signed [c_pw-1:0] r_p_ai;
    logic signed [c_pw-1:0] r_p_br;

    logic signed [c_sw-1:0] w_p_r;
    logic signed [c_sw-1:0] w_p_i;
    logic signed [DW-1:0]   w_res_r;
    logic signed [DW-1:0]   w_res_i;

    // A start-of-frame sample always takes index 0, regardless of r_k.
    assign w_k_use = in_sof ? 3'd0 : r_k;

    always_comb begin
        w_wr = '0;
        w_wi = '0;
        case (w_k_use)
            3'd0: begin w_wr = TW'(128);  w_wi = TW'(0);    end
            3'd1: begin w_wr = TW'(118);  w_wi = TW'(-48);  end
            3'd2: begin w_wr = TW'(90);   w_wi = TW'(-90);  end
            3'd3: begin w_wr = TW'(48);   w_wi = TW'(-118); end
            3'd4: begin w_wr = TW'(0);    w_wi = TW'(-128); end
            3'd5: begin w_wr = TW'(-48);  w_wi = TW'(-118); end
            3'd6: begin w_wr = TW'(-90);  w_wi = TW'(-90);  end
            default: begin w_wr = TW'(-118); w_wi = TW'(-48); end
        endcase
    end

    assign w_a = c_pw'(in_r);
    assign w_b = c_pw'(in_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= 3'd0;
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_k     <= 3'd0;
            r_p_ar     <= '0;
            r_p_bi     <= '0;
            r_p_ai     <= '0;
            r_p_br     <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_k      <= w_k_use + 3'd1;
                r_s1_sof <= in_sof;
                r_s1_k   <= w_k_use;
                r_p_ar   <= w_a * c_pw'(w_wr);
                r_p_bi   <= w_b * c_pw'(w_wi);
                r_p_ai   <= w_a * c_pw'(w_wi);
                r_p_br   <= w_b * c_pw'(w_wr);
            end
        end
    end

    // Round half-up in Q1.7, then clamp into the signed output range.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [c_sw-1:0] p);
        logic signed [c_rw-1:0] v;
        v = (c_rw'(p) + c_round) >>> 7;
        if (v > c_max)
            return DW'(c_max);
        else if (v < c_min)
            return DW'(c_min);
        else
            return DW'(v);
    endfunction

    assign w_p_r   = c_sw'(r_p_ar) - c_sw'(r_p_bi);
    assign w_p_i   = c_sw'(r_p_ai) + c_sw'(r_p_br);
    assign w_res_r = round_sat(w_p_r);
    assign w_res_i = round_sat(w_p_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_k     <= 3'd0;
            out_r     <= '0;
            out_i     <= '0;
        end else begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_sof <= r_s1_sof;
                out_k   <= r_s1_k;
                out_r   <= w_res_r;
                out_i   <= w_res_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_twiddle_mult8.sv
// ============================================================================
//  Module   : tb_twiddle_mult8
//  Purpose  : Scoreboard bench for twiddle_mult8.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_twiddle_mult8;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_sof = 1'b0;
    logic signed [DW-1:0] in_r = '0;
    logic signed [DW-1:0] in_i = '0;
    logic                 out_valid;
    logic                 out_sof;
    logic [2:0]           out_k;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;

    twiddle_mult8 #(.DW(DW), .TW(9)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_r     (in_r),
        .in_i     (in_i),
        .out_valid(out_valid),
        .out_sof  (out_sof),
        .out_k    (out_k),
        .out_r    (out_r),
        .out_i    (out_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     due;
        int     k;
        int     sof;
        longint r;
        longint i;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_k = 0;
    int   wr_tab[8] = '{128, 118, 90, 48, 0, -48, -90, -118};
    int   wi_tab[8] = '{0, -48, -90, -118, -128, -118, -90, -48};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint rnd_sat(input longint p);
        longint v;
        v = (p + 64) >>> 7;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rnd_data();
        logic signed [15:0] t;
        case ($urandom % 8)
            0: return -32768;
            1: return 32767;
            default: begin
                t = 16'($urandom);
                return int'(t);
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances the model index and returns the index this sample uses.
    function automatic int take_k(input logic sof);
        int k;
        k = sof ? 0 : m_k;
        m_k = (k + 1) % 8;
        return k;
    endfunction

    task automatic drive_push(input logic sof, input int a, input int b,
                              input int ek, input longint er, input longint ei);
        in_valid = 1'b1;
        in_sof   = sof;
        in_r     = DW'(a);
        in_i     = DW'(b);
        sb.push_back('{cyc + 2, ek, int'(sof), er, ei});
        tick();
    endtask

    task automatic send(input logic sof, input int a, input int b);
        int k;
        longint pr, pi;
        k  = take_k(sof);
        pr = longint'(a) * wr_tab[k] - longint'(b) * wi_tab[k];
        pi = longint'(a) * wi_tab[k] + longint'(b) * wr_tab[k];
        drive_push(sof, a, b, k, rnd_sat(pr), rnd_sat(pi));
    endtask

    task automatic send_exp(input logic sof, input int a, input int b,
                            input int ek, input longint er, input longint ei);
        int k;
        k = take_k(sof);
        drive_push(sof, a, b, ek, er, ei);
    endtask

    task automatic idle(input logic sof);
        in_valid = 1'b0;
        in_sof   = sof;
        in_r     = DW'(rnd_data());
        in_i     = DW'(rnd_data());
        tick();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_valid"}, out_valid, 0);
        check_val({tag, "_sof"},   out_sof,   0);
        check_val({tag, "_k"},     out_k,     0);
        check_val({tag, "_r"},     out_r,     0);
        check_val({tag, "_i"},     out_i,     0);
    endtask

    // Output monitor: samples well after the driver has moved its inputs.
    logic signed [DW-1:0] l_r = '0;
    logic signed [DW-1:0] l_i = '0;
    logic [2:0]           l_k = '0;
    logic                 l_sof = 1'b0;

    always begin : mon
        exp_t e;
        @(posedge clk);
        #3;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("latency", cyc,     e.due);
                check_val("out_k",   out_k,   e.k);
                check_val("out_sof", out_sof, e.sof);
                check_val("out_r",   out_r,   e.r);
                check_val("out_i",   out_i,   e.i);
            end
        end else if (rst_n) begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                check_val("missing_valid", 0, 1);
                e = sb.pop_front();
            end
            check_val("hold_r",   out_r,   l_r);
            check_val("hold_i",   out_i,   l_i);
            check_val("hold_k",   out_k,   l_k);
            check_val("hold_sof", out_sof, l_sof);
        end
        l_r   = out_r;
        l_i   = out_i;
        l_k   = out_k;
        l_sof = out_sof;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        check_zero("reset");
        rst_n = 1'b1;
        m_k   = 0;
        tick();

        // First samples after reset start at index 0 without sof.
        send_exp(1'b0, 100, 0, 0, 100, 0);
        send_exp(1'b0, 100, 0, 1, 92, -37);
        repeat (3) idle(1'b0);

        send(1'b1, 1, 1);
        send(1'b0, 5, -3);
        send_exp(1'b0, 1000, 1000, 2, 1406, 0);
        idle(1'b0);

        // Saturation at index 4.
        send(1'b1, 7, 9);
        for (int n = 0; n < 3; n++) send(1'b0, rnd_data(), rnd_data());
        send_exp(1'b0, 0, -32768, 4, -32768, 0);
        send(1'b1, -5, 4);
        for (int n = 0; n < 3; n++) send(1'b0, rnd_data(), rnd_data());
        send_exp(1'b0, -32768, 0, 4, 0, 32767);
        repeat (3) idle(1'b0);

        // sof without valid must not reset the index.
        idle(1'b1);
        send(1'b0, 300, -200);
        idle(1'b0);

        // Wrap, then mid-group resync.
        for (int n = 0; n < 10; n++) send(n == 0, rnd_data(), rnd_data());
        idle(1'b0);
        for (int n = 0; n < 10; n++) send(n == 0 || n == 3, rnd_data(), rnd_data());
        idle(1'b0);

        // Bubbles.
        send(1'b1, 1234, -4321);
        idle(1'b0);
        send(1'b0, -777, 888);
        idle(1'b0);
        send(1'b0, 32767, 32767);
        repeat (3) idle(1'b0);

        // Reset with samples in the pipeline.
        send(1'b1, 2000, 3000);
        send(1'b0, -2000, 1500);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        m_k = 0;
        #1;
        check_zero("midrst");
        tick();
        rst_n = 1'b1;
        repeat (4) idle(1'b0);
        send(1'b0, 500, -500);
        send(1'b0, 500, -500);
        repeat (3) idle(1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom % 10 < 7)
                send(($urandom % 8) == 0, rnd_data(), rnd_data());
            else
                idle(1'($urandom % 2));
        end
        repeat (4) idle(1'b0);
        check_val("drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
